// File: rtl/cwalk_pkg.sv
// Shared constants and types for the crosswalk controller and its countdown timer.
package cwalk_pkg;

  localparam int unsigned CNT_W        = 4;
  localparam logic [6:0]  SEG_OFF      = 7'h7F;
  localparam int unsigned TICK_DIV_DEF = 50_000_000;
  localparam int unsigned LOAD_VAL_DEF = 15;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/cwalk_sseg_decoder.sv
// Combinational hex digit to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
module cwalk_sseg_decoder
  import cwalk_pkg::*;
(
  input  cnt_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/cwalk_timer.sv
// Crosswalk countdown timer: prescaler, seconds down-counter and registered
// single-digit display driver.
module cwalk_timer
  import cwalk_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned LOAD_VAL  = LOAD_VAL_DEF,
  parameter int unsigned C7_THRESH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             num_on,
  output logic [CNT_W-1:0] count,
  output logic             c7,
  output logic             tc,
  output logic [6:0]       seg,
  output logic             an
);

  localparam int unsigned   PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam cnt_t          LOAD    = CNT_W'(LOAD_VAL);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [6:0]    seg_dec;

  // Idle, run and terminal behaviour all fall out of en and count directly,
  // so no separate state register is kept.
  assign tick = en && (prescaler == PRE_MAX);
  assign tc   = tick && (count == '0);
  assign c7   = en && (32'(count) <= C7_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      count     <= LOAD;
    end else if (!en) begin
      prescaler <= '0;
      count     <= LOAD;
    end else if (tick) begin
      prescaler <= '0;
      count     <= (count == '0) ? LOAD : count - 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  cwalk_sseg_decoder u_dec (
    .digit (count),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= 1'b1;
    end else begin
      seg <= num_on ? seg_dec : SEG_OFF;
      an  <= ~num_on;
    end
  end

endmodule

// File: doc/cwalk_timer.md
Name: cwalk_timer

Overview:
- Countdown timer that drives the crosswalk controller's timing inputs and the pedestrian countdown display.
- Consumes en and num_on from the crosswalk FSM; produces c7 (count at or below threshold) and tc (terminal count) back to it.
- Contains a clock prescaler, a seconds down-counter and a 7-segment digit driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per count step (1 s at 50 MHz); legal range 2 or more.
- LOAD_VAL, 15, value loaded into the counter; legal range 1 to 15.
- C7_THRESH, 7, c7 is asserted while count is at or below this value.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable from the FSM.
- num_on  input  1  display enable from the FSM.
- count  output  4  current countdown value.
- c7  output  1  high when en and count <= C7_THRESH.
- tc  output  1  one-cycle terminal-count pulse.
- seg  output  7  active-low segments {g,f,e,d,c,b,a} for count.
- an  output  1  active-low digit enable.

Behaviour:
- Reset (clk edge with reset high):
  - prescaler = 0, count = LOAD_VAL, tc = 0.
  - c7 = 0, an = 1, seg = 7'h7F (all off).
- Reset overrides en on the same edge.
- Prescaler:
  - Counter of width clog2(TICK_DIV).
  - While en = 0 it is held at 0.
  - While en = 1 it increments each cycle. At TICK_DIV-1 it wraps to 0 and raises the internal tick for that one cycle.
- Counter states:
  - IDLE (en = 0): count is forced to LOAD_VAL every cycle, so dropping en mid-count reloads it.
  - RUN (en = 1): on a tick with count > 0, count decrements by 1.
  - TERMINAL: on a tick with count == 0, tc = 1 for exactly that cycle and count reloads to LOAD_VAL on the next edge. The counter wraps if en stays high.
- First tick after en rises arrives TICK_DIV cycles after the rising edge. tc therefore fires (LOAD_VAL+1)*TICK_DIV cycles after en rises, i.e. the display shows 0 for one full period.
- tc and c7 are combinational from registered state (count, prescaler, en): zero latency relative to count.
- c7 is gated by en. c7 = 1 during the cycle tc = 1, since count == 0.
- Simultaneous events:
  - en falling on the tick cycle: en = 0 wins, count reloads, and tc is not produced.
  - en = 0 forces tc = 0.
- Display:
  - an = ~num_on.
  - seg = hex-digit decode of count when num_on = 1, else 7'h7F.
  - seg and an are registered: one-cycle latency from count and num_on.
  - Decode must cover 0 to F (0 = 7'b1000000, 7 = 7'b1111000, F = 7'b0001110).
- No arithmetic overflow is possible: count never decrements below 0 and the prescaler wraps explicitly.

Decomposition:
- Shared package cwalk_pkg:
  - CNT_W = 4.
  - SEG_OFF = 7'h7F.
  - Default TICK_DIV and LOAD_VAL.
  - Same package is used by the crosswalk FSM.
- One sub-module, cwalk_sseg_decoder: purely combinational 4-bit to 7-segment active-low decoder. It is instantiated here, and cwalk_timer owns the output register.

Test Plan (TICK_DIV = 4, LOAD_VAL = 15, C7_THRESH = 7):
- Reset:
  - Stimulus: reset high 2 cycles, en = 1.
  - Required: count = 15, tc = 0, c7 = 0, seg = 7'h7F, an = 1.
  - After release, the first decrement to 14 occurs 4 cycles later.
- Full countdown:
  - Stimulus: en = 1 held.
  - Required: count steps 15 to 0, one step every 4 cycles; c7 rises when count becomes 7.
  - tc pulses exactly once, 64 cycles after en rose, 1 cycle wide; count returns to 15 the next cycle.
- Abort:
  - Stimulus: en dropped while count = 9, prescaler mid-way.
  - Required: next cycle count = 15, c7 = 0, no tc.
  - Re-raising en restarts the full 64-cycle period.
- Tick collision:
  - Stimulus: en deasserted on the exact cycle count = 0 and tick = 1.
  - Required: tc = 0, count = 15.
- Display:
  - Stimulus: num_on toggled during the countdown.
  - Required: seg follows the decode of count with 1-cycle latency when num_on = 1 (count 7 gives 7'b1111000); seg = 7'h7F and an = 1 when num_on = 0.
- Reset mid-run:
  - Stimulus: reset asserted at count = 3 with en = 1.
  - Required: next edge count = 15, prescaler = 0, tc = 0.
